// File: rtl/spart_io_arbiter.sv
// spart_io_arbiter: round-robin sharing of the SPART memory-mapped I/O port between two requesters.
// Optional watchdog abort of unacknowledged transactions when SPART_ARB_TIMEOUT_EN is defined.
module spart_io_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req0_rw,
  input  logic [27:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic [31:0] req0_rdata,
  output logic        req0_err,
  input  logic        req1_valid,
  input  logic        req1_rw,
  input  logic [27:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic [31:0] req1_rdata,
  output logic        req1_err,
  output logic        io_valid_data,
  output logic        io_rw_data,
  output logic [27:0] mem_addr,
  output logic [31:0] io_wr_data,
  input  logic        io_ready_data,
  input  logic [31:0] io_rd_data
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("spart_io_arbiter: TIMEOUT_CYCLES must be within 2..65535");
  end

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic        io_valid_q, io_valid_d;
  logic        io_rw_q, io_rw_d;
  logic [27:0] mem_addr_q, mem_addr_d;
  logic [31:0] io_wr_data_q, io_wr_data_d;
  logic [1:0]  ready_q, ready_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        grant_any;
  logic        grant_sel;
  logic        expire;

`ifdef SPART_ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_cnt_q, wd_cnt_d;
  assign expire = (wd_cnt_q == WD_LAST);
`else
  assign expire = 1'b0;
`endif

  // On a tie the port that did not win last time gets the grant.
  assign grant_any = req0_valid | req1_valid;
  assign grant_sel = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    io_valid_d   = io_valid_q;
    io_rw_d      = io_rw_q;
    mem_addr_d   = mem_addr_q;
    io_wr_data_d = io_wr_data_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    ready_d      = 2'b00;
    err_d        = 2'b00;
`ifdef SPART_ARB_TIMEOUT_EN
    wd_cnt_d     = wd_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          owner_d      = grant_sel;
          last_grant_d = grant_sel;
          io_rw_d      = grant_sel ? req1_rw    : req0_rw;
          mem_addr_d   = grant_sel ? req1_addr  : req0_addr;
          io_wr_data_d = grant_sel ? req1_wdata : req0_wdata;
          io_valid_d   = 1'b1;
          state_d      = BUSY;
`ifdef SPART_ARB_TIMEOUT_EN
          wd_cnt_d     = 16'd0;
`endif
        end
      end
      BUSY: begin
        if (io_ready_data) begin
          io_valid_d       = 1'b0;
          state_d          = RESP;
          ready_d[owner_q] = 1'b1;
          if (owner_q) rdata1_d = io_rd_data;
          else         rdata0_d = io_rd_data;
        end else if (expire) begin
          io_valid_d       = 1'b0;
          state_d          = RESP;
          ready_d[owner_q] = 1'b1;
          err_d[owner_q]   = 1'b1;
          if (owner_q) rdata1_d = 32'hDEADBEEF;
          else         rdata0_d = 32'hDEADBEEF;
        end else begin
`ifdef SPART_ARB_TIMEOUT_EN
          wd_cnt_d = wd_cnt_q + 16'd1;
`endif
        end
      end
      RESP: state_d = IDLE;
      default: begin
        state_d    = IDLE;
        io_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      io_valid_q   <= 1'b0;
      io_rw_q      <= 1'b0;
      mem_addr_q   <= 28'd0;
      io_wr_data_q <= 32'd0;
      ready_q      <= 2'b00;
      err_q        <= 2'b00;
      rdata0_q     <= 32'd0;
      rdata1_q     <= 32'd0;
`ifdef SPART_ARB_TIMEOUT_EN
      wd_cnt_q     <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      io_valid_q   <= io_valid_d;
      io_rw_q      <= io_rw_d;
      mem_addr_q   <= mem_addr_d;
      io_wr_data_q <= io_wr_data_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
`ifdef SPART_ARB_TIMEOUT_EN
      wd_cnt_q     <= wd_cnt_d;
`endif
    end
  end

  assign io_valid_data = io_valid_q;
  assign io_rw_data    = io_rw_q;
  assign mem_addr      = mem_addr_q;
  assign io_wr_data    = io_wr_data_q;
  assign req0_ready    = ready_q[0];
  assign req1_ready    = ready_q[1];
  assign req0_err      = err_q[0];
  assign req1_err      = err_q[1];
  assign req0_rdata    = rdata0_q;
  assign req1_rdata    = rdata1_q;

endmodule

// File: tb/tb_spart_io_arbiter.sv
// Bench for spart_io_arbiter: directed vector table, alternation/reset/watchdog sequences,
// and a randomized run checked against a cycle-timing reference model of the arbitration rules.
module tb_spart_io_arbiter;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v [2];
  logic        rwv [2];
  logic [27:0] av [2];
  logic [31:0] wv [2];
  logic        req0_ready, req1_ready, req0_err, req1_err;
  logic [31:0] req0_rdata, req1_rdata;
  logic        io_valid_data, io_rw_data;
  logic [27:0] mem_addr;
  logic [31:0] io_wr_data;
  logic        io_ready_data;
  logic [31:0] io_rd_data;
  logic [31:0] rdat [2];

  int checks = 0;
  int errors = 0;
  int last_m = 1;

  always #5 clk = ~clk;

  assign rdat[0] = req0_rdata;
  assign rdat[1] = req1_rdata;

  spart_io_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v[0]), .req0_rw(rwv[0]), .req0_addr(av[0]), .req0_wdata(wv[0]),
    .req0_ready(req0_ready), .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(v[1]), .req1_rw(rwv[1]), .req1_addr(av[1]), .req1_wdata(wv[1]),
    .req1_ready(req1_ready), .req1_rdata(req1_rdata), .req1_err(req1_err),
    .io_valid_data(io_valid_data), .io_rw_data(io_rw_data), .mem_addr(mem_addr),
    .io_wr_data(io_wr_data), .io_ready_data(io_ready_data), .io_rd_data(io_rd_data)
  );

  typedef struct {
    bit          v0, v1, rw0, rw1;
    logic [27:0] a0, a1;
    logic [31:0] w0, w1, rd0, rd1;
    int          lat;
    int          first;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int p);
    v[p]   = 1'b1;
    rwv[p] = 1'($urandom);
    av[p]  = 28'($urandom);
    wv[p]  = $urandom;
  endtask

  // Waits for the grant of port p, holds the command for lat extra cycles, then acks with rd.
  task automatic serve(input int p, input int lat, input logic [31:0] rd, input bit renew,
                       output int gap);
    int n = 0;
    while (!io_valid_data && n < 20) begin
      step();
      n++;
    end
    gap = n;
    chk("grant_seen", 32'(io_valid_data), 32'd1);
    if (!io_valid_data) return;
    last_m = p;
    for (int i = 0; i <= lat; i++) begin
      chk("cmd_addr", 32'(mem_addr), 32'(av[p]));
      chk("cmd_rw", 32'(io_rw_data), 32'(rwv[p]));
      chk("cmd_wdata", io_wr_data, wv[p]);
      chk("busy_valid", 32'(io_valid_data), 32'd1);
      chk("busy_ready", 32'({req1_ready, req0_ready}), 32'd0);
      if (i == lat) begin
        io_ready_data = 1'b1;
        io_rd_data    = rd;
      end
      step();
    end
    io_ready_data = 1'b0;
    io_rd_data    = $urandom;
    chk("resp_valid", 32'(io_valid_data), 32'd0);
    chk("resp_ready_owner", 32'(p == 0 ? req0_ready : req1_ready), 32'd1);
    chk("resp_ready_other", 32'(p == 0 ? req1_ready : req0_ready), 32'd0);
    chk("resp_rdata", rdat[p], rd);
    chk("resp_err", 32'({req1_err, req0_err}), 32'd0);
    if (renew) new_req(p);
    else v[p] = 1'b0;
  endtask

  // Reference model: a grant happens at the end of any idle cycle with a pending request,
  // ties go to the port not granted last, a BUSY cycle with ack is followed by one RESP cycle.
  task automatic random_phase();
    bit          free_cur = 1'b1;
    bit          valid_cur = 1'b0;
    bit          ack, gen, exp_valid;
    int          owner = 0;
    int          cd = 0;
    logic [1:0]  exp_rdy;
    logic [31:0] exp_rd;
    for (int cyc = 0; cyc < 700; cyc++) begin
      gen = (cyc < 500);
      if (!gen && free_cur && !v[0] && !v[1]) break;
      for (int p = 0; p < 2; p++)
        if (gen && !v[p] && $urandom_range(0, 2) == 0) new_req(p);
      if (valid_cur) begin
        io_ready_data = (cd == 0);
        if (cd > 0) cd--;
      end else begin
        io_ready_data = ($urandom_range(0, 3) == 0);
      end
      io_rd_data = $urandom;
      ack        = valid_cur && io_ready_data;
      exp_valid  = (free_cur && (v[0] || v[1])) || (valid_cur && !ack);
      if (free_cur && (v[0] || v[1])) begin
        owner  = (v[0] && v[1]) ? 1 - last_m : (v[1] ? 1 : 0);
        last_m = owner;
        cd     = $urandom_range(0, 5);
      end
      exp_rdy = 2'b00;
      if (ack) exp_rdy[owner] = 1'b1;
      exp_rd = io_rd_data;
      step();
      chk("rand_valid", 32'(io_valid_data), 32'(exp_valid));
      chk("rand_ready", 32'({req1_ready, req0_ready}), 32'(exp_rdy));
      chk("rand_err", 32'({req1_err, req0_err}), 32'd0);
      if (ack) chk("rand_rdata", rdat[owner], exp_rd);
      if (exp_valid) begin
        chk("rand_addr", 32'(mem_addr), 32'(av[owner]));
        chk("rand_rw", 32'(io_rw_data), 32'(rwv[owner]));
        chk("rand_wdata", io_wr_data, wv[owner]);
      end
      if (ack) begin
        if (gen && $urandom_range(0, 1) == 1) new_req(owner);
        else v[owner] = 1'b0;
      end
      free_cur  = !exp_valid && !ack;
      valid_cur = exp_valid;
    end
    io_ready_data = 1'b0;
    chk("rand_drained", 32'(free_cur && !v[0] && !v[1]), 32'd1);
  endtask

  initial begin
    int gap;
    int p;
    int n;
    v[0] = 1'b0; v[1] = 1'b0; rwv[0] = 1'b0; rwv[1] = 1'b0;
    av[0] = '0; av[1] = '0; wv[0] = '0; wv[1] = '0;
    io_ready_data = 1'b0;
    io_rd_data    = '0;

    tbl[0] = '{1, 1, 1, 0, 28'h0000008, 28'h000000C, 32'hA5A5A5A5, 32'h0,
               32'h11111111, 32'h22222222, 2, 0};
    tbl[1] = '{1, 0, 0, 0, 28'h0000004, 28'h0, 32'h0, 32'h0,
               32'h00000041, 32'h0, 5, 0};
    tbl[2] = '{0, 1, 0, 1, 28'h0, 28'hFFFFFFC, 32'h0, 32'hCAFEF00D,
               32'h0, 32'h0BADF00D, 1, 1};
    tbl[3] = '{1, 1, 0, 1, 28'h0000100, 28'h0000200, 32'h0, 32'h12345678,
               32'h33333333, 32'h44444444, 0, 0};
    tbl[4] = '{0, 1, 0, 0, 28'h0, 28'h000003C, 32'h0, 32'h0,
               32'h0, 32'h55555555, 3, 1};
    tbl[5] = '{1, 1, 1, 1, 28'hFFFFFFF, 28'h0000010, 32'hFFFFFFFF, 32'h00000001,
               32'h66666666, 32'h77777777, 1, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(io_valid_data), 32'd0);
    chk("rst_rw", 32'(io_rw_data), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", io_wr_data, 32'd0);
    chk("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    chk("rst_rdata0", req0_rdata, 32'd0);
    chk("rst_rdata1", req1_rdata, 32'd0);
    chk("rst_err", 32'({req1_err, req0_err}), 32'd0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      v[0] = tbl[i].v0;  v[1] = tbl[i].v1;
      rwv[0] = tbl[i].rw0; rwv[1] = tbl[i].rw1;
      av[0] = tbl[i].a0; av[1] = tbl[i].a1;
      wv[0] = tbl[i].w0; wv[1] = tbl[i].w1;
      p = tbl[i].first;
      serve(p, tbl[i].lat, (p == 1) ? tbl[i].rd1 : tbl[i].rd0, 1'b0, gap);
      if (tbl[i].v0 && tbl[i].v1) begin
        p = 1 - p;
        serve(p, tbl[i].lat, (p == 1) ? tbl[i].rd1 : tbl[i].rd0, 1'b0, gap);
        chk("tie_gap", 32'(gap), 32'd2);
      end
      step();
      chk("rdata_hold", rdat[p], (p == 1) ? tbl[i].rd1 : tbl[i].rd0);
    end

    new_req(0);
    new_req(1);
    for (int k = 0; k < 6; k++) begin
      serve(k % 2, 1, $urandom, k < 4, gap);
      if (k > 0) chk("alt_gap", 32'(gap), 32'd2);
    end
    step();

    random_phase();

    new_req(0);
    step();
    chk("pre_rst_valid", 32'(io_valid_data), 32'd1);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_valid", 32'(io_valid_data), 32'd0);
    chk("async_rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    chk("async_rst_addr", 32'(mem_addr), 32'd0);
    v[0] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    last_m = 1;
    step();
    chk("post_rst_idle", 32'(io_valid_data), 32'd0);
    new_req(0);
    new_req(1);
    serve(0, 0, 32'h0BEEF000, 1'b0, gap);
    serve(1, 0, 32'h0BEEF001, 1'b0, gap);
    chk("post_rst_gap", 32'(gap), 32'd2);
    step();

`ifdef SPART_ARB_TIMEOUT_EN
    new_req(0);
    step();
    chk("wd_start", 32'(io_valid_data), 32'd1);
    n = 0;
    while (io_valid_data && n < 40) begin
      n++;
      step();
    end
    chk("wd_valid_cycles", 32'(n), 32'(TO));
    chk("wd_ready", 32'(req0_ready), 32'd1);
    chk("wd_err", 32'(req0_err), 32'd1);
    chk("wd_rdata", req0_rdata, 32'hDEADBEEF);
    chk("wd_other", 32'({req1_err, req1_ready}), 32'd0);
    v[0] = 1'b0;
    last_m = 0;
    step();
    new_req(0);
    serve(0, 3, 32'h600DF00D, 1'b0, gap);
    step();
`else
    n = 0;
`endif

    new_req(0);
    serve(0, TO - 1, 32'h12345678, 1'b0, gap);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, limit 500000", $time);
    $fatal(1, "bench watchdog expired");
  end

endmodule

// File: doc/spart_io_arbiter.md
# spart_io_arbiter

Two-port arbiter sharing the single SPART memory-mapped I/O port between two requesters: port 0 (data cache) and port 1 (boot loader / debug master). It sits between the requesters and the SPART I/O slave port (`io_valid_data` / `io_ready_data` handshake, 28-bit address, 32-bit data). It grants one transaction at a time using round-robin, registers the selected command onto the SPART port, and returns completion and read data to the owning requester only. An optional watchdog aborts transactions the SPART never acknowledges.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: busy cycles allowed before watchdog abort (2..65535).

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req0_valid` / `req1_valid` in 1: request pending. Held with rw/addr/wdata stable until the matching `reqN_ready`.
- `req0_rw` / `req1_rw` in 1: 1 = write, 0 = read.
- `req0_addr` / `req1_addr` in 28: I/O address.
- `req0_wdata` / `req1_wdata` in 32: write data.
- `req0_ready` / `req1_ready` out 1: one-cycle completion pulse.
- `req0_rdata` / `req1_rdata` out 32: read data, valid during `reqN_ready`; holds its value otherwise.
- `req0_err` / `req1_err` out 1: pulses with `reqN_ready` on watchdog abort.
- `io_valid_data` out 1: command valid to SPART.
- `io_rw_data` out 1: rw of the owning requester.
- `mem_addr` out 28: address of the owning requester.
- `io_wr_data` out 32: write data of the owning requester.
- `io_ready_data` in 1: SPART completion.
- `io_rd_data` in 32: SPART read data, sampled when `io_ready_data` = 1.

## Operation
- FSM states: IDLE, BUSY, RESP. Reset state is IDLE.
- IDLE
  - No valid request: stay in IDLE.
  - Exactly one valid request: grant it.
  - Both valid: grant the port that was not `last_grant`. `last_grant` resets to 1, so port 0 wins the first tie.
  - On grant: register `owner`, rw, addr and wdata into output flops; set `last_grant` = owner; go to BUSY.
- BUSY
  - `io_valid_data` = 1; command outputs held constant.
  - On `io_ready_data` = 1: capture `io_rd_data` into the owner's rdata register, then go to RESP.
- RESP
  - `io_valid_data` = 0.
  - Owner's `reqN_ready` = 1 for exactly this cycle; the non-owner's ready stays 0.
  - Requester valids are ignored in this state.
  - Always go to IDLE next cycle.
- The non-owner's request waits untouched and is granted at the next IDLE.
- Command outputs hold their last values in IDLE and RESP. They are don't-care while `io_valid_data` = 0, but must not glitch.
- `io_ready_data` is ignored outside BUSY.
- Reset values:
  - All outputs 0: valid, rw, `mem_addr`, `io_wr_data`, readies, rdatas, errs.
  - `owner` = 0, watchdog counter = 0.
- Reset asserted mid-transaction drops `io_valid_data` immediately. No completion is issued; the requester must reissue.

## Timing
- Request seen at IDLE edge N → `io_valid_data` high from cycle N+1.
- `io_ready_data` sampled high at edge M → `reqN_ready` and rdata presented in cycle M+1 (RESP) → IDLE at M+2.
- Best case: 3 cycles from request to ready pulse when SPART acknowledges in its first BUSY cycle.
- Minimum 1 IDLE cycle between back-to-back transactions. Maximum sustained throughput is 1 transaction per 3 cycles.
- A requester sampling its ready high must deassert valid (or present a new request) on the following cycle. The arbiter re-samples valid in IDLE.

## Configuration
- `SPART_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entering BUSY and increments each BUSY cycle without `io_ready_data`.
  - When the count reaches `TIMEOUT_CYCLES`-1 without `io_ready_data`: go to RESP, load owner's rdata with 32'hDEADBEEF, and pulse owner's `reqN_err` together with `reqN_ready`.
  - `io_ready_data` arriving in the same cycle as expiry wins: normal completion, no error.
- Not defined:
  - No counter; BUSY waits indefinitely.
  - `req0_err` / `req1_err` tied to 0. Ports are present in both builds.

## Test plan
- Single read, port 0, addr 28'h0000004, SPART acks 5 cycles after `io_valid_data` with 32'h00000041 → `mem_addr` = 28'h0000004 and `io_rw_data` = 0 while valid; `req0_ready` pulses one cycle with `req0_rdata` = 32'h00000041; `req1_ready` stays 0.
- Simultaneous requests from reset: port 0 write 32'hA5A5A5A5 to 28'h0000008, port 1 read 28'h000000C → port 0 served first; port 1 is presented after a 1-cycle IDLE gap.
- Both ports requesting continuously for 6 transactions → grants alternate 0,1,0,1,0,1; each gap between `io_valid_data` pulses is exactly 2 cycles low (RESP + IDLE).
- Reset asserted during BUSY → `io_valid_data` and all readies go 0 asynchronously; after release, state is IDLE and the first tie goes to port 0.
- With `SPART_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 16, SPART never acks → `io_valid_data` high for exactly 16 cycles, then `req0_ready` = `req0_err` = 1 with rdata 32'hDEADBEEF; the next request proceeds normally.
- With `SPART_ARB_TIMEOUT_EN`, `io_ready_data` arriving on the expiry cycle → normal completion, `req0_err` = 0, rdata = `io_rd_data`.
